out_compare_monitor: RTL
========================

# out_compare_monitor

Synthesizable response checker that sits directly downstream of the design-under-test and its golden model in the post-route equivalence harness. It consumes both 32-bit output buses and compares them a fixed number of cycles after each stimulus change. It counts compared vectors and mismatches, captures the first failing vector, and reports pass/fail once a programmed number of vectors has been checked. This replaces the behavioural compare task so the check can also run on hardware.

## Interface
Parameters:
- WIDTH, 32, width of the compared output buses
- NUM_VECTORS, 1000, vectors to compare before DONE (must be ≥1)
- SETTLE, 2, rising edges from stim_valid sample to compare sample (must be ≥1)
- CNT_W, 16, width of vector and mismatch counters

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  begin a run; sampled only in IDLE or DONE
- stim_valid  in  1  one-cycle pulse: new stimulus applied this cycle
- golden  in  WIDTH  golden-model output
- dut  in  WIDTH  netlist output
- busy  out  1  run in progress
- done  out  1  run finished, held until next start
- pass  out  1  done and zero mismatches and no overrun
- overrun  out  1  sticky: stim_valid arrived while a compare was pending
- err_strobe  out  1  one-cycle pulse on each mismatching compare
- vec_count  out  CNT_W  vectors compared in this run
- mismatch_count  out  CNT_W  mismatches in this run, saturating at all-ones
- first_fail_idx  out  CNT_W  vec_count value of first mismatch
- first_fail_golden  out  WIDTH  golden value at first mismatch
- first_fail_dut  out  WIDTH  dut value at first mismatch

## Operation
- States: IDLE, WAIT_STIM, SETTLE, COMPARE, DONE.
- IDLE: on start go to WAIT_STIM. Clear counters, overrun, first_fail_* and done.
- WAIT_STIM: on stim_valid go to SETTLE, loading settle counter with SETTLE-1.
- SETTLE: decrement each cycle. At 0, go to COMPARE. With SETTLE=1, go directly to COMPARE on the next edge.
- COMPARE: the mismatch test is (golden ^ dut) != 0.
  - On mismatch: pulse err_strobe and increment mismatch_count (saturating).
  - On the first mismatch only, capture first_fail_idx, first_fail_golden and first_fail_dut.
  - Then increment vec_count. If the new value equals NUM_VECTORS go to DONE, else go to WAIT_STIM.
- A stim_valid during SETTLE or COMPARE is not queued. It sets overrun, and the pending compare continues unaffected.
- DONE: assert done. pass = (mismatch_count==0) && !overrun. On start, clear and go to WAIT_STIM.
- start is ignored while busy. busy = state in {WAIT_STIM, SETTLE, COMPARE}.
- vec_count does not wrap: NUM_VECTORS ≤ 2^CNT_W − 1 is required and is checked by an elaboration assertion.

## Timing
- Reset values: state IDLE. All outputs are 0, including every first_fail_* field.
- Reset is asynchronous, and asserting it mid-run aborts immediately to IDLE with all outputs 0. Deassertion is synchronized externally.
- If stim_valid is sampled at edge E, golden/dut are sampled at edge E+SETTLE.
- err_strobe, counters and first_fail_* update at edge E+SETTLE and are visible immediately after it.
- done/pass are visible after the edge E+SETTLE+1 that follows the final compare.
- stim_valid sampled in the same cycle as the exit from COMPARE to WAIT_STIM counts as overrun. Minimum legal spacing between stim_valid pulses is SETTLE+1 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package out_compare_pkg holds:
  - the state enum (state_e)
  - default parameter constants
  - a localparam helper function computing the required CNT_W for a given NUM_VECTORS
- Sub-module sat_counter (parameter W): increment enable, synchronous clear, asynchronous active-low reset, holds at all-ones. Instantiated for mismatch_count and vec_count.
- Single FSM plus capture registers in the top module, with no other hierarchy.

## Test plan
- Clean run: NUM_VECTORS=4, SETTLE=2, golden==dut, stim_valid every 3 cycles → vec_count=4, mismatch_count=0, done=1, pass=1, err_strobe never high.
- Single fault: vector 2 has golden=32'h0000_00FF, dut=32'h0000_00FE → exactly one err_strobe, mismatch_count=1, first_fail_idx=2, first_fail_golden=32'hFF, first_fail_dut=32'hFE, pass=0.
- Multiple faults: mismatches on vectors 1 and 3 → mismatch_count=2, first_fail_idx=1 (not 3), first_fail_* unchanged by the second fault.
- Overrun: stim_valid pulses 1 cycle apart with SETTLE=2 → overrun=1, vec_count increments once per accepted pulse only, pass=0 at DONE even with no mismatches.
- Saturation: CNT_W=2, NUM_VECTORS=3, all mismatching → mismatch_count=3 and holds, err_strobe pulses 3 times, done=1.
- Reset mid-run: assert rst=0 asynchronously during SETTLE of vector 2 → all outputs 0 immediately, state IDLE. A fresh start then runs the clean sequence to pass=1.

Source files
------------

// File: rtl/out_compare_pkg.sv
// Shared types and defaults for the output-compare monitor: FSM state encoding,
// default parameter values and the counter-width helper.
package out_compare_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_STIM,
      ST_SETTLE,
      ST_COMPARE,
      ST_DONE
   } state_e;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_NUM_VECTORS = 1000;
   localparam int DEF_SETTLE      = 2;
   localparam int DEF_CNT_W       = 16;

   // Smallest counter width that can hold n without wrapping.
   function automatic int cnt_w_for(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/out_compare_monitor_if.sv
// Bus between the stimulus/DUT side (master) and the compare monitor (slave).
interface out_compare_monitor_if
   import out_compare_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);
   logic             start;
   logic             stim_valid;
   logic [WIDTH-1:0] golden;
   logic [WIDTH-1:0] dut;
   logic             busy;
   logic             done;
   logic             pass;
   logic             overrun;
   logic             err_strobe;
   logic [CNT_W-1:0] vec_count;
   logic [CNT_W-1:0] mismatch_count;
   logic [CNT_W-1:0] first_fail_idx;
   logic [WIDTH-1:0] first_fail_golden;
   logic [WIDTH-1:0] first_fail_dut;

   modport master (
      output start, stim_valid, golden, dut,
      input  busy, done, pass, overrun, err_strobe, vec_count, mismatch_count,
             first_fail_idx, first_fail_golden, first_fail_dut
   );

   modport slave (
      input  start, stim_valid, golden, dut,
      output busy, done, pass, overrun, err_strobe, vec_count, mismatch_count,
             first_fail_idx, first_fail_golden, first_fail_dut
   );
endinterface

// File: rtl/out_compare_monitor_sat_counter.sv
// Saturating up-counter: clear wins over increment, holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;

   // NOTE: sequential state is written only with non-blocking assignments so every
   // flop samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/out_compare_monitor.sv
// Response checker: compares golden vs netlist outputs SETTLE edges after each
// stimulus, counts vectors/mismatches, captures the first failure, reports pass.
module out_compare_monitor
   import out_compare_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int NUM_VECTORS = DEF_NUM_VECTORS,
   parameter int SETTLE      = DEF_SETTLE,
   parameter int CNT_W       = DEF_CNT_W
) (
   input logic                  clk,
   input logic                  rst,
   out_compare_monitor_if.slave bus
);
   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   if (NUM_VECTORS < 1 || SETTLE < 1 || CNT_W < cnt_w_for(NUM_VECTORS)) begin : g_bad_params
      $error("out_compare_monitor: NUM_VECTORS/SETTLE must be >= 1 and fit in CNT_W");
   end

   state_e           state_q, state_d;
   logic [SCW-1:0]   settle_q, settle_d;
   logic             overrun_q, done_q, pass_q, err_q;
   logic [CNT_W-1:0] ff_idx_q;
   logic [WIDTH-1:0] ff_golden_q, ff_dut_q;

   logic             clear;
   logic             compare_en;
   logic             mismatch;
   logic             first_fail;
   logic             last_vec;
   logic             in_done;
   logic [CNT_W-1:0] vec_count, mis_count;
   logic [CNT_W:0]   vec_next;

   assign compare_en = (state_q == ST_COMPARE);
   assign mismatch   = |(bus.golden ^ bus.dut);
   assign first_fail = compare_en && mismatch && (mis_count == '0);
   assign vec_next   = {1'b0, vec_count} + (CNT_W+1)'(1);
   assign last_vec   = (vec_next == (CNT_W+1)'(NUM_VECTORS));
   assign in_done    = (state_q == ST_DONE) && !bus.start;

   // NOTE: every signal assigned in this block gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      clear    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d = ST_WAIT_STIM;
               clear   = 1'b1;
            end
         end
         ST_WAIT_STIM: begin
            if (bus.stim_valid) begin
               settle_d = SCW'(SETTLE - 1);
               state_d  = (SETTLE == 1) ? ST_COMPARE : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            settle_d = settle_q - SCW'(1);
            if (settle_q == SCW'(1)) state_d = ST_COMPARE;
         end
         ST_COMPARE: begin
            state_d = last_vec ? ST_DONE : ST_WAIT_STIM;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         settle_q    <= '0;
         overrun_q   <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= 1'b0;
         ff_idx_q    <= '0;
         ff_golden_q <= '0;
         ff_dut_q    <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         err_q    <= compare_en && mismatch;
         // done/pass follow the registered DONE state, one edge after the last compare.
         done_q   <= in_done;
         pass_q   <= in_done && (mis_count == '0) && !overrun_q;

         if (clear) begin
            overrun_q <= 1'b0;
         end else if (bus.stim_valid && (state_q == ST_SETTLE || state_q == ST_COMPARE)) begin
            overrun_q <= 1'b1;
         end

         if (clear) begin
            ff_idx_q    <= '0;
            ff_golden_q <= '0;
            ff_dut_q    <= '0;
         end else if (first_fail) begin
            ff_idx_q    <= vec_count;
            ff_golden_q <= bus.golden;
            ff_dut_q    <= bus.dut;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_vec_cnt (
      .clk   (clk),
      .rst_n (rst),
      .clr_i (clear),
      .inc_i (compare_en),
      .cnt_o (vec_count)
   );

   sat_counter #(.W(CNT_W)) u_mis_cnt (
      .clk   (clk),
      .rst_n (rst),
      .clr_i (clear),
      .inc_i (compare_en && mismatch),
      .cnt_o (mis_count)
   );

   assign bus.busy              = (state_q == ST_WAIT_STIM) || (state_q == ST_SETTLE) ||
                                  (state_q == ST_COMPARE);
   assign bus.done              = done_q;
   assign bus.pass              = pass_q;
   assign bus.overrun           = overrun_q;
   assign bus.err_strobe        = err_q;
   assign bus.vec_count         = vec_count;
   assign bus.mismatch_count    = mis_count;
   assign bus.first_fail_idx    = ff_idx_q;
   assign bus.first_fail_golden = ff_golden_q;
   assign bus.first_fail_dut    = ff_dut_q;
endmodule
